// File: rtl/btn_pulse_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// default debounce/repeat constants.
package btn_pulse_debouncer_pkg;

  // Debouncer FSM state encodings
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  // Default debounce constants
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 4;
  localparam int DEF_REPEAT_CYCLES   = 8;

endpackage

// File: rtl/btn_pulse_debouncer_sync_2ff.sv
// Two-flop synchroniser for a raw asynchronous level, with synchronous
// active-high reset. Output q follows d with two cycles of latency.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/btn_pulse_debouncer.sv
// Push-button conditioner: synchronises a bouncy button level, debounces it
// with a counter-based FSM, and emits one single-cycle pulse per accepted
// press plus a clean debounced level.
// Optional macro BTN_AUTO_REPEAT_EN: while the button stays held, an extra
// pulse is issued every REPEAT_CYCLES cycles.
module btn_pulse_debouncer
  import btn_pulse_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out,
  output logic level_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_s;
  logic             w_cnt_last;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_btn_s)
  );

  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep;
  logic             w_rep_fire;

  assign w_rep_fire = (r_state == ST_HELD) && w_btn_s && (r_rep == REP_LAST);

  // Repeat counter runs only while held; it is zero whenever HELD is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep <= '0;
    end else if ((r_state == ST_HELD) && w_btn_s && !w_rep_fire) begin
      r_rep <= r_rep + 1'b1;
    end else begin
      r_rep <= '0;
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = (REPEAT_CYCLES != 0);
`endif

  // Debounce FSM; reaching the terminal count always changes state, so the
  // counter never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_btn_s) begin
            r_state <= ST_PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!w_btn_s) begin
            r_state <= ST_IDLE;
          end else if (w_cnt_last) begin
            r_state <= ST_HELD;
            r_pulse <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_btn_s) begin
            r_state <= ST_RELEASE_CHK;
            r_cnt   <= '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (w_rep_fire) begin
            r_pulse <= 1'b1;
          end
`endif
        end
        ST_RELEASE_CHK: begin
          if (w_btn_s) begin
            r_state <= ST_HELD;
          end else if (w_cnt_last) begin
            r_state <= ST_IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pulse_out = r_pulse;
  assign level_out = r_level;

endmodule

// File: doc/btn_pulse_debouncer.md
Name: btn_pulse_debouncer

Overview:
- Upstream conditioning stage for the 4-bit JK-based up counter.
- Takes a raw, asynchronous, bouncy push-button level and synchronises it to clk.
- Debounces it with a counter-based FSM and emits exactly one single-cycle pulse per accepted press.
- pulse_out drives the counter's clock/advance input; level_out gives a clean debounced level for LEDs and status.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a press or release; legal range 1..2^CNT_W.
- CNT_W, 4: width of the debounce counter.
- REPEAT_CYCLES, 8: auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw button level, asynchronous to clk.
- pulse_out  output  1  one-cycle strobe per accepted press (and per repeat, if enabled).
- level_out  output  1  debounced button level.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: sync flops 0, state IDLE, cnt 0, pulse_out 0, level_out 0. All outputs are registered.
- Synchroniser: btn_in passes through 2 flops, giving btn_s with 2-cycle latency.
- IDLE:
  - btn_s=1 -> PRESS_CHK, cnt<=0.
- PRESS_CHK:
  - btn_s=0 -> IDLE (glitch rejected, no pulse).
  - Otherwise cnt<=cnt+1.
  - When cnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> HELD, pulse_out<=1 for one cycle, level_out<=1.
- HELD:
  - btn_s=0 -> RELEASE_CHK, cnt<=0.
- RELEASE_CHK:
  - btn_s=1 -> HELD (bounce; no new pulse, level_out stays 1).
  - Otherwise cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 -> IDLE, level_out<=0.
- Latency: with btn_in first sampled high at edge 1 and held stable, pulse_out and level_out rise after edge DEBOUNCE_CYCLES+3 (edge 7 for the default). Release is symmetric: level_out falls after edge DEBOUNCE_CYCLES+3 counted from the first low sample.
- pulse_out is never high for two consecutive cycles unless auto-repeat is enabled and REPEAT_CYCLES==1.
- cnt saturates and never wraps; reaching the terminal value always forces a state change.
- Reset mid-operation: any state returns to IDLE with no pulse. A button still held after rst deasserts counts as a new press, and pulses DEBOUNCE_CYCLES+3 edges after the first post-reset edge.
- rst overrides all other inputs in the same cycle.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: in HELD with btn_s=1, a repeat counter increments each cycle. It clears on entry to HELD and on return from RELEASE_CHK. Every REPEAT_CYCLES cycles it issues another one-cycle pulse_out and clears.
- Undefined: exactly one pulse per press. The repeat counter and REPEAT_CYCLES logic are absent.

Decomposition:
- Shared package: FSM state encodings IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, RELEASE_CHK=2'd3; default debounce constants.
- Sub-module sync_2ff: 2-flop synchroniser with synchronous active-high reset. It is reusable for other raw inputs in the lab designs.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=4, REPEAT_CYCLES=8):
- Clean press: btn_in 0->1, held 20 cycles -> single pulse_out after edge 7; level_out 1 from edge 7; no further pulses.
- Glitch: btn_in high for 2 cycles, then low -> pulse_out and level_out stay 0 throughout.
- Bouncy release: after HELD, btn_in toggles every cycle for 5 cycles, then stays 0 -> no extra pulse; level_out falls 7 edges after the final low sample.
- Reset mid-press: btn_in held; rst asserted at edge 5 for 1 cycle -> no pulse before reset; pulse_out 7 edges after rst deasserts.
- Integration: 5 clean presses with pulse_out driving the up counter -> counter output L=4'b0101, with no double counts.
- Auto-repeat:
  - With BTN_AUTO_REPEAT_EN, btn_in held 40 cycles -> pulses after edges 7, 15, 23, 31, 39.
  - Without the macro -> only the pulse after edge 7.
